// File: rtl/mips_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the execute stage: ALUOp/funct codes, internal ALU op enum,
// multiplier FSM states and the debug snapshot struct.
package mips_pkg;

    localparam int DATA_W  = 32;
    localparam int MUL_CYC = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MFHI,
        ALU_MFLO,
        ALU_MULT,
        ALU_MULTU
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    typedef struct packed {
        mul_state_e  state;
        logic        mul_busy;
        logic [4:0]  mul_cnt;
    } ex_dbg_t;

    // Unknown funct codes fall back to add so stray encodings still produce a defined result.
    function automatic alu_op_e decode_alu(input logic [1:0] aluop, input logic [5:0] funct);
        alu_op_e op;
        op = ALU_ADD;
        case (aluop)
            ALUOP_ADD, ALUOP_ADD2: op = ALU_ADD;
            ALUOP_SUB:             op = ALU_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD:   op = ALU_ADD;
                    FUNCT_SUB:   op = ALU_SUB;
                    FUNCT_AND:   op = ALU_AND;
                    FUNCT_OR:    op = ALU_OR;
                    FUNCT_SLT:   op = ALU_SLT;
                    FUNCT_MFHI:  op = ALU_MFHI;
                    FUNCT_MFLO:  op = ALU_MFLO;
                    FUNCT_MULT:  op = ALU_MULT;
                    FUNCT_MULTU: op = ALU_MULTU;
                    default:     op = ALU_ADD;
                endcase
            end
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
`timescale 1ns/1ps
// ID/EX input bundle and EX/MEM output bundle of the execute stage.
// master = pipeline side driving EX_*; slave = ex_stage.
interface ex_stage_if;
    import mips_pkg::*;

    logic                EX_RegDst;
    logic                EX_RegWrite;
    logic                EX_Branch;
    logic                EX_MemRead;
    logic                EX_MemWrite;
    logic                EX_ALUSrc;
    logic                EX_MemtoReg;
    logic [1:0]          EX_ALUOp;
    logic [DATA_W-1:0]   EX_pc_plus_4;
    logic [DATA_W-1:0]   EX_rdata1;
    logic [DATA_W-1:0]   EX_rdata2;
    logic [DATA_W-1:0]   EX_const_or_addr;
    logic [4:0]          EX_rt;
    logic [4:0]          EX_rd;

    logic                ex_stall;
    logic                MEM_RegWrite;
    logic                MEM_Branch;
    logic                MEM_MemRead;
    logic                MEM_MemWrite;
    logic                MEM_MemtoReg;
    logic [DATA_W-1:0]   MEM_alu_result;
    logic                MEM_zero;
    logic [DATA_W-1:0]   MEM_wdata;
    logic [DATA_W-1:0]   MEM_branch_target;
    logic [4:0]          MEM_wreg;

    modport master (
        output EX_RegDst, EX_RegWrite, EX_Branch, EX_MemRead, EX_MemWrite, EX_ALUSrc,
               EX_MemtoReg, EX_ALUOp, EX_pc_plus_4, EX_rdata1, EX_rdata2,
               EX_const_or_addr, EX_rt, EX_rd,
        input  ex_stall, MEM_RegWrite, MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg,
               MEM_alu_result, MEM_zero, MEM_wdata, MEM_branch_target, MEM_wreg
    );

    modport slave (
        input  EX_RegDst, EX_RegWrite, EX_Branch, EX_MemRead, EX_MemWrite, EX_ALUSrc,
               EX_MemtoReg, EX_ALUOp, EX_pc_plus_4, EX_rdata1, EX_rdata2,
               EX_const_or_addr, EX_rt, EX_rd,
        output ex_stall, MEM_RegWrite, MEM_Branch, MEM_MemRead, MEM_MemWrite, MEM_MemtoReg,
               MEM_alu_result, MEM_zero, MEM_wdata, MEM_branch_target, MEM_wreg
    );

endinterface

// File: rtl/ex_stage_mult_iter.sv
`timescale 1ns/1ps
// Iterative unsigned W x W -> 2W shift-add multiplier, one partial product per cycle.
// o_done is high during the final step; o_product is valid the cycle after.
module mult_iter #(
    parameter int W   = 32,
    parameter int CYC = 32,
    localparam int CW = $clog2(CYC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [W-1:0]     i_a,
    input  logic [W-1:0]     i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [CW-1:0]    o_cnt,
    output logic [2*W-1:0]   o_product
);

    logic [2*W-1:0] r_mcand;
    logic [2*W-1:0] r_acc;
    logic [W-1:0]   r_mplr;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           w_last;

    assign w_last = r_busy && (r_cnt == CW'(CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_mcand <= {{W{1'b0}}, i_a};
            r_mplr  <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else if (r_busy) begin
            if (r_mplr[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = w_last;
    assign o_cnt     = r_cnt;
    assign o_product = r_acc;

endmodule

// File: rtl/ex_stage.sv
`timescale 1ns/1ps
// MIPS execute stage: ALU, branch target, dest select, HI/LO with an iterative
// MULT/MULTU that stalls upstream, and the EX/MEM pipeline register.
module ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = mips_pkg::DATA_W,
    parameter int MUL_CYC = mips_pkg::MUL_CYC
) (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   bus,
    output ex_dbg_t     o_dbg
);

    mul_state_e          r_state;
    mul_state_e          w_state_nxt;
    logic                r_neg;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;

    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [DATA_W-1:0]   w_sum;
    logic [DATA_W-1:0]   w_diff;
    logic [DATA_W-1:0]   w_result;
    logic [DATA_W-1:0]   w_target;
    logic [DATA_W-1:0]   w_a_mag;
    logic [DATA_W-1:0]   w_b_mag;
    logic [2*DATA_W-1:0] w_product;
    logic [2*DATA_W-1:0] w_product_fix;
    logic [4:0]          w_wreg;
    logic [4:0]          w_mul_cnt;
    alu_op_e             w_op;
    logic                w_is_mul;
    logic                w_signed_mul;
    logic                w_slt;
    logic                w_stall;
    logic                w_bubble;
    logic                w_mul_start;
    logic                w_mul_busy;
    logic                w_mul_done;
    logic                w_hilo_we;

    logic                r_mem_regwrite;
    logic                r_mem_branch;
    logic                r_mem_memread;
    logic                r_mem_memwrite;
    logic                r_mem_memtoreg;
    logic [DATA_W-1:0]   r_mem_alu_result;
    logic                r_mem_zero;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_mem_branch_target;
    logic [4:0]          r_mem_wreg;

    assign w_a          = bus.EX_rdata1;
    assign w_b          = bus.EX_ALUSrc ? bus.EX_const_or_addr : bus.EX_rdata2;
    assign w_op         = decode_alu(bus.EX_ALUOp, bus.EX_const_or_addr[5:0]);
    assign w_is_mul     = (w_op == ALU_MULT) || (w_op == ALU_MULTU);
    assign w_signed_mul = (w_op == ALU_MULT);
    assign w_sum        = w_a + w_b;
    assign w_diff       = w_a - w_b;
    assign w_slt        = $signed(w_a) < $signed(w_b);
    assign w_target     = bus.EX_pc_plus_4 + {bus.EX_const_or_addr[DATA_W-3:0], 2'b00};
    assign w_wreg       = bus.EX_RegDst ? bus.EX_rd : bus.EX_rt;

    always_comb begin
        w_result = w_sum;
        case (w_op)
            ALU_SUB:  w_result = w_diff;
            ALU_AND:  w_result = w_a & w_b;
            ALU_OR:   w_result = w_a | w_b;
            ALU_SLT:  w_result = {{(DATA_W-1){1'b0}}, w_slt};
            ALU_MFHI: w_result = r_hi;
            ALU_MFLO: w_result = r_lo;
            default:  w_result = w_sum;
        endcase
    end

    // Signed multiply runs on magnitudes; the sign is reapplied when HI/LO is written.
    // 0x80000000 negates to itself, which is still the correct unsigned magnitude.
    assign w_a_mag = (w_signed_mul && w_a[DATA_W-1]) ? -w_a : w_a;
    assign w_b_mag = (w_signed_mul && w_b[DATA_W-1]) ? -w_b : w_b;

    mult_iter #(
        .W   (DATA_W),
        .CYC (MUL_CYC)
    ) u_mult (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (w_a_mag),
        .i_b       (w_b_mag),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_cnt     (w_mul_cnt),
        .o_product (w_product)
    );

    assign w_product_fix = r_neg ? -w_product : w_product;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DONE deliberately does not look at EX_*: the mult is still presented there
    // for one more cycle and must not be reissued.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_bubble    = 1'b0;
        w_mul_start = 1'b0;
        w_hilo_we   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_is_mul) begin
                    w_stall     = 1'b1;
                    w_bubble    = 1'b1;
                    w_mul_start = 1'b1;
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                if (w_mul_done) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_bubble    = 1'b1;
                w_hilo_we   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg <= 1'b0;
            r_hi  <= '0;
            r_lo  <= '0;
        end else begin
            if (w_mul_start) begin
                r_neg <= w_signed_mul && (w_a[DATA_W-1] ^ w_b[DATA_W-1]);
            end
            if (w_hilo_we) begin
                r_hi <= w_product_fix[2*DATA_W-1:DATA_W];
                r_lo <= w_product_fix[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_regwrite      <= 1'b0;
            r_mem_branch        <= 1'b0;
            r_mem_memread       <= 1'b0;
            r_mem_memwrite      <= 1'b0;
            r_mem_memtoreg      <= 1'b0;
            r_mem_alu_result    <= '0;
            r_mem_zero          <= 1'b0;
            r_mem_wdata         <= '0;
            r_mem_branch_target <= '0;
            r_mem_wreg          <= '0;
        end else begin
            r_mem_regwrite      <= bus.EX_RegWrite & ~w_bubble;
            r_mem_branch        <= bus.EX_Branch   & ~w_bubble;
            r_mem_memread       <= bus.EX_MemRead  & ~w_bubble;
            r_mem_memwrite      <= bus.EX_MemWrite & ~w_bubble;
            r_mem_memtoreg      <= bus.EX_MemtoReg & ~w_bubble;
            r_mem_alu_result    <= w_result;
            r_mem_zero          <= (w_diff == '0);
            r_mem_wdata         <= bus.EX_rdata2;
            r_mem_branch_target <= w_target;
            r_mem_wreg          <= w_wreg;
        end
    end

    assign bus.ex_stall          = w_stall;
    assign bus.MEM_RegWrite      = r_mem_regwrite;
    assign bus.MEM_Branch        = r_mem_branch;
    assign bus.MEM_MemRead       = r_mem_memread;
    assign bus.MEM_MemWrite      = r_mem_memwrite;
    assign bus.MEM_MemtoReg      = r_mem_memtoreg;
    assign bus.MEM_alu_result    = r_mem_alu_result;
    assign bus.MEM_zero          = r_mem_zero;
    assign bus.MEM_wdata         = r_mem_wdata;
    assign bus.MEM_branch_target = r_mem_branch_target;
    assign bus.MEM_wreg          = r_mem_wreg;

    assign o_dbg.state    = r_state;
    assign o_dbg.mul_busy = w_mul_busy;
    assign o_dbg.mul_cnt  = w_mul_cnt;

endmodule

// File: tb/tb_ex_stage.sv
`timescale 1ns/1ps
// Directed bench for ex_stage: ALU ops, branch target, dest select, reset,
// signed/unsigned iterative multiply with stall timing and reset abort.
module tb_ex_stage;
  import mips_pkg::*;

  logic    clk;
  logic    rst;
  ex_dbg_t dbg;
  int      n_checks;
  int      n_errors;

  ex_stage_if bus();

  ex_stage dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .o_dbg (dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_ex(input logic [1:0] aluop, input logic [31:0] a, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic alusrc, input logic regdst,
                        input logic regwrite, input logic branch, input logic memread,
                        input logic memwrite, input logic memtoreg, input logic [31:0] pc4,
                        input logic [4:0] rt, input logic [4:0] rd);
    bus.EX_ALUOp         = aluop;
    bus.EX_rdata1        = a;
    bus.EX_rdata2        = rd2;
    bus.EX_const_or_addr = imm;
    bus.EX_ALUSrc        = alusrc;
    bus.EX_RegDst        = regdst;
    bus.EX_RegWrite      = regwrite;
    bus.EX_Branch        = branch;
    bus.EX_MemRead       = memread;
    bus.EX_MemWrite      = memwrite;
    bus.EX_MemtoReg      = memtoreg;
    bus.EX_pc_plus_4     = pc4;
    bus.EX_rt            = rt;
    bus.EX_rd            = rd;
  endtask

  task automatic set_r(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b);
    set_ex(2'b10, a, b, {26'h0, funct}, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
           32'h0, 5'd3, 5'd7);
  endtask

  task automatic check_mem_zero(input string tag);
    check({tag, "_regwrite"}, 64'(bus.MEM_RegWrite), 64'd0);
    check({tag, "_branch"},   64'(bus.MEM_Branch),   64'd0);
    check({tag, "_memread"},  64'(bus.MEM_MemRead),  64'd0);
    check({tag, "_memwrite"}, 64'(bus.MEM_MemWrite), 64'd0);
    check({tag, "_memtoreg"}, 64'(bus.MEM_MemtoReg), 64'd0);
  endtask

  // Full multiply: stall count, bubble controls, then HI/LO via mfhi/mflo.
  task automatic run_mul(input string tag, input logic [5:0] funct, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stall_cycles;
    int guard;
    set_r(funct, a, b);
    #1;
    check({tag, "_stall_comb"}, 64'(bus.ex_stall), 64'd1);
    stall_cycles = 0;
    guard = 0;
    while (bus.ex_stall && guard < 100) begin
      stall_cycles++;
      guard++;
      tick();
      check({tag, "_bubble_rw"}, 64'(bus.MEM_RegWrite), 64'd0);
    end
    check({tag, "_stall_cycles"}, 64'(stall_cycles), 64'd33);
    check({tag, "_done_state"}, 64'(dbg.state), 64'(ST_DONE));
    tick();
    check({tag, "_done_bubble"}, 64'(bus.MEM_RegWrite), 64'd0);
    check({tag, "_idle_state"}, 64'(dbg.state), 64'(ST_IDLE));
    set_r(FUNCT_MFHI, 32'h0, 32'h0);
    tick();
    check({tag, "_mfhi"}, 64'(bus.MEM_alu_result), 64'(exp_hi));
    check({tag, "_mfhi_rw"}, 64'(bus.MEM_RegWrite), 64'd1);
    set_r(FUNCT_MFLO, 32'h0, 32'h0);
    tick();
    check({tag, "_mflo"}, 64'(bus.MEM_alu_result), 64'(exp_lo));
  endtask

  logic [5:0]  fn_tbl  [4];
  logic [31:0] a_tbl   [4];
  logic [31:0] b_tbl   [4];
  logic [31:0] exp_tbl [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    fn_tbl[0] = FUNCT_AND; a_tbl[0] = 32'hF0F0_00FF; b_tbl[0] = 32'h0FF0_0F0F; exp_tbl[0] = 32'h00F0_000F;
    fn_tbl[1] = FUNCT_OR;  a_tbl[1] = 32'hF0F0_00FF; b_tbl[1] = 32'h0FF0_0F0F; exp_tbl[1] = 32'hFFF0_0FFF;
    fn_tbl[2] = FUNCT_SUB; a_tbl[2] = 32'd10;        b_tbl[2] = 32'd3;         exp_tbl[2] = 32'd7;
    fn_tbl[3] = 6'h27;     a_tbl[3] = 32'h0000_1234; b_tbl[3] = 32'h0000_0100; exp_tbl[3] = 32'h0000_1334;

    rst = 1'b1;
    set_r(FUNCT_ADD, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_stall", 64'(bus.ex_stall), 64'd0);
    check("rst_result", 64'(bus.MEM_alu_result), 64'd0);
    check("rst_wreg", 64'(bus.MEM_wreg), 64'd0);
    check("rst_state", 64'(dbg.state), 64'(ST_IDLE));
    check_mem_zero("rst");
    rst = 1'b0;

    set_r(FUNCT_ADD, 32'hFFFF_FFFF, 32'h1);
    tick();
    check("add_result", 64'(bus.MEM_alu_result), 64'd0);
    check("add_zero", 64'(bus.MEM_zero), 64'd0);
    check("add_rw", 64'(bus.MEM_RegWrite), 64'd1);
    check("add_wreg", 64'(bus.MEM_wreg), 64'd7);

    set_ex(2'b01, 32'd5, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
           32'h100, 5'd4, 5'd8);
    tick();
    check("beq_zero", 64'(bus.MEM_zero), 64'd1);
    check("beq_target", 64'(bus.MEM_branch_target), 64'h0000_00F8);
    check("beq_branch", 64'(bus.MEM_Branch), 64'd1);
    check("beq_rw", 64'(bus.MEM_RegWrite), 64'd0);

    set_r(FUNCT_SLT, 32'hFFFF_FFFF, 32'h1);
    tick();
    check("slt_result", 64'(bus.MEM_alu_result), 64'd1);
    check("slt_zero", 64'(bus.MEM_zero), 64'd0);

    set_ex(2'b00, 32'h20, 32'h55, 32'h10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
           32'h0, 5'd9, 5'd12);
    tick();
    check("lw_result", 64'(bus.MEM_alu_result), 64'h30);
    check("lw_wreg", 64'(bus.MEM_wreg), 64'd9);
    check("lw_wdata", 64'(bus.MEM_wdata), 64'h55);
    check("lw_memread", 64'(bus.MEM_MemRead), 64'd1);
    check("lw_memtoreg", 64'(bus.MEM_MemtoReg), 64'd1);

    set_ex(2'b11, 32'h1000, 32'hDEAD, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
           32'h0, 5'd2, 5'd0);
    tick();
    check("sw_result", 64'(bus.MEM_alu_result), 64'h1004);
    check("sw_memwrite", 64'(bus.MEM_MemWrite), 64'd1);
    check("sw_wdata", 64'(bus.MEM_wdata), 64'hDEAD);

    for (int i = 0; i < 4; i++) begin
      set_r(fn_tbl[i], a_tbl[i], b_tbl[i]);
      tick();
      check($sformatf("rtype%0d_result", i), 64'(bus.MEM_alu_result), 64'(exp_tbl[i]));
    end

    // reset mid-run after a GPR-writing op
    set_r(FUNCT_ADD, 32'h1, 32'h2);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("rst2_stall", 64'(bus.ex_stall), 64'd0);
    check("rst2_result", 64'(bus.MEM_alu_result), 64'd0);
    check_mem_zero("rst2");
    rst = 1'b0;
    set_r(FUNCT_MFHI, 32'h0, 32'h0);
    tick();
    check("rst2_mfhi", 64'(bus.MEM_alu_result), 64'd0);

    run_mul("mult", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_mul("multu", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    // reset abort at BUSY cycle 10
    set_r(FUNCT_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    check("abort_stall", 64'(bus.ex_stall), 64'd1);
    repeat (11) tick();
    check("abort_busy_state", 64'(dbg.state), 64'(ST_BUSY));
    check("abort_busy_cnt", 64'(dbg.mul_cnt), 64'd10);
    rst = 1'b1;
    set_r(FUNCT_MFHI, 32'h0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("abort_state", 64'(dbg.state), 64'(ST_IDLE));
    check("abort_stall_low", 64'(bus.ex_stall), 64'd0);
    check("abort_mul_busy", 64'(dbg.mul_busy), 64'd0);
    check_mem_zero("abort");
    tick();
    check("abort_mfhi", 64'(bus.MEM_alu_result), 64'd0);
    set_r(FUNCT_MFLO, 32'h0, 32'h0);
    tick();
    check("abort_mflo", 64'(bus.MEM_alu_result), 64'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
